// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline control types and constants
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    INIT = 3'd0,
    RUN  = 3'd1,
    HALT = 3'd2,
    STEP = 3'd3
  } state_t;

endpackage

// File: rtl/pipeline_control_if.sv
// rtl/pipeline_control_if.sv - hazard, redirect and debug signals of the sequencer
interface pipeline_control_if #(parameter int CNT_W = 16);
  import mips_pkg::*;

  logic [REG_ADDR_W-1:0] idRegAddr1;
  logic [REG_ADDR_W-1:0] idRegAddr2;
  logic                  idUsesReg2;
  logic                  exMemRead;
  logic [REG_ADDR_W-1:0] exWriteAddr;
  logic                  takeBranch;
  logic                  haltReq;
  logic                  stepReq;
  logic                  pcWrite;
  logic                  ifIdWrite;
  logic                  ifIdFlush;
  logic                  idExFlush;
  logic                  exMemFlush;
  logic                  halted;
  logic                  stepDone;
  logic [CNT_W-1:0]      stallCount;

  modport master (
    output idRegAddr1, idRegAddr2, idUsesReg2, exMemRead, exWriteAddr,
           takeBranch, haltReq, stepReq,
    input  pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush,
           halted, stepDone, stallCount
  );

  modport slave (
    input  idRegAddr1, idRegAddr2, idUsesReg2, exMemRead, exWriteAddr,
           takeBranch, haltReq, stepReq,
    output pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush,
           halted, stepDone, stallCount
  );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use hazard between the EX load and the ID operands
module hazard_detect
  import mips_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] idRegAddr1,
  input  logic [REG_ADDR_W-1:0] idRegAddr2,
  input  logic                  idUsesReg2,
  input  logic                  exMemRead,
  input  logic [REG_ADDR_W-1:0] exWriteAddr,
  output logic                  hz
);

  // $zero is never a real dependency, so a load targeting it cannot stall.
  assign hz = exMemRead && (exWriteAddr != REG_ZERO) &&
              ((exWriteAddr == idRegAddr1) ||
               (idUsesReg2 && (exWriteAddr == idRegAddr2)));

endmodule

// File: rtl/pipeline_control.sv
// rtl/pipeline_control.sv - PC/IF-ID enables, bubble flushes, debug halt/step, stall counter
module pipeline_control
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  pipeline_control_if.slave bus
);

  state_t     state, state_next;
  logic       hz;
  logic       stall_inc;

  hazard_detect u_hazard (
    .idRegAddr1  (bus.idRegAddr1),
    .idRegAddr2  (bus.idRegAddr2),
    .idUsesReg2  (bus.idUsesReg2),
    .exMemRead   (bus.exMemRead),
    .exWriteAddr (bus.exWriteAddr),
    .hz          (hz)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= INIT;
    else          state <= state_next;
  end

  always_comb begin
    state_next     = state;
    bus.pcWrite    = 1'b0;
    bus.ifIdWrite  = 1'b0;
    bus.ifIdFlush  = 1'b0;
    bus.idExFlush  = 1'b0;
    bus.exMemFlush = 1'b0;
    bus.halted     = 1'b0;
    bus.stepDone   = 1'b0;
    stall_inc      = 1'b0;

    case (state)
      RUN, STEP: begin
        // A taken redirect squashes the ID instruction, so its hazard is moot.
        if (bus.takeBranch) begin
          bus.pcWrite    = 1'b1;
          bus.ifIdWrite  = 1'b1;
          bus.ifIdFlush  = 1'b1;
          bus.idExFlush  = 1'b1;
          bus.exMemFlush = 1'b1;
        end else if (hz) begin
          bus.idExFlush  = 1'b1;
          stall_inc      = 1'b1;
        end else begin
          bus.pcWrite    = 1'b1;
          bus.ifIdWrite  = 1'b1;
        end

        if (state == RUN) begin
          if (bus.haltReq && !bus.takeBranch) state_next = HALT;
        end else if (!(hz && !bus.takeBranch)) begin
          bus.stepDone = 1'b1;
          state_next   = HALT;
        end
      end
      HALT: begin
        bus.idExFlush = 1'b1;
        bus.halted    = 1'b1;
        if (!bus.haltReq)    state_next = RUN;
        else if (bus.stepReq) state_next = STEP;
      end
      default: begin
        bus.ifIdFlush  = 1'b1;
        bus.idExFlush  = 1'b1;
        bus.exMemFlush = 1'b1;
        state_next     = bus.haltReq ? HALT : RUN;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      bus.stallCount <= '0;
    else if (stall_inc && (bus.stallCount != {CNT_W{1'b1}}))
      bus.stallCount <= bus.stallCount + 1'b1;
  end

endmodule

// File: tb/tb_pipeline_control.sv
// tb/tb_pipeline_control.sv - directed vector bench for pipeline_control
module tb_pipeline_control;

  localparam int CNT_W = 4;

  logic clock;
  logic reset_n;
  int   errors = 0;
  int   checks = 0;

  pipeline_control_if #(.CNT_W(CNT_W)) bus ();

  pipeline_control #(.CNT_W(CNT_W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Outputs packed as {pcWrite, ifIdWrite, ifIdFlush, idExFlush, exMemFlush, halted, stepDone}.
  localparam logic [6:0] O_RST  = 7'b0011100;
  localparam logic [6:0] O_RUN  = 7'b1100000;
  localparam logic [6:0] O_STL  = 7'b0001000;
  localparam logic [6:0] O_BR   = 7'b1111100;
  localparam logic [6:0] O_HLT  = 7'b0001010;
  localparam logic [6:0] O_SDN  = 7'b1100001;

  typedef struct {
    logic [4:0] a1;
    logic [4:0] a2;
    logic       u2;
    logic       mr;
    logic [4:0] wa;
    logic       tb;
    logic       hr;
    logic       sr;
    logic [6:0] exp_o;
    logic [3:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic u2,
                              input logic mr, input logic [4:0] wa, input logic tb,
                              input logic hr, input logic sr, input logic [6:0] eo,
                              input logic [3:0] ec);
    vec_t v;
    v.a1 = a1; v.a2 = a2; v.u2 = u2; v.mr = mr; v.wa = wa;
    v.tb = tb; v.hr = hr; v.sr = sr; v.exp_o = eo; v.exp_cnt = ec;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {bus.pcWrite, bus.ifIdWrite, bus.ifIdFlush, bus.idExFlush,
            bus.exMemFlush, bus.halted, bus.stepDone};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic u2,
                       input logic mr, input logic [4:0] wa, input logic tb,
                       input logic hr, input logic sr);
    bus.idRegAddr1 = a1; bus.idRegAddr2 = a2; bus.idUsesReg2 = u2;
    bus.exMemRead = mr; bus.exWriteAddr = wa; bus.takeBranch = tb;
    bus.haltReq = hr; bus.stepReq = sr;
  endtask

  task automatic idle();
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    //        a1  a2  u2 mr  wa  tb hr sr  outputs  cnt
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0));   // INIT
    vecs.push_back(mk(8, 0, 0, 1, 8, 0, 0, 0, O_STL, 0));   // rs load-use
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, O_RUN, 1));   // load to $zero
    vecs.push_back(mk(3, 9, 0, 1, 9, 0, 0, 0, O_RUN, 1));   // rt unused
    vecs.push_back(mk(3, 9, 1, 1, 9, 0, 0, 0, O_STL, 1));   // rt used
    vecs.push_back(mk(8, 0, 0, 1, 8, 1, 1, 0, O_BR,  2));   // branch beats hz and halt
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_RUN, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_HLT, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, O_HLT, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_SDN, 2));   // step, no hazard
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_HLT, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, O_HLT, 2));
    vecs.push_back(mk(8, 0, 0, 1, 8, 0, 1, 0, O_STL, 2));   // step stalled once
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_SDN, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_HLT, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, O_RUN, 3));   // stepReq ignored in RUN
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, O_RUN, 3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, O_HLT, 3));
    vecs.push_back(mk(8, 0, 0, 1, 8, 0, 0, 0, O_STL, 3));   // haltReq drops mid-step
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_SDN, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_HLT, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, O_RUN, 4));

    reset_n = 1'b0;
    idle();
    @(negedge clock);
    #1;
    check("reset_outs", 32'(outs()), 32'(O_RST));
    check("reset_cnt", 32'(bus.stallCount), 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].a1, vecs[i].a2, vecs[i].u2, vecs[i].mr, vecs[i].wa,
            vecs[i].tb, vecs[i].hr, vecs[i].sr);
      #1;
      check($sformatf("vec%0d_outs", i), 32'(outs()), 32'(vecs[i].exp_o));
      check($sformatf("vec%0d_cnt", i), 32'(bus.stallCount), 32'(vecs[i].exp_cnt));
      @(negedge clock);
    end

    // Twenty stall cycles starting from 4 must pin the counter at 15.
    for (int i = 0; i < 20; i++) begin
      drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
    end
    idle();
    #1;
    check("sat_cnt", 32'(bus.stallCount), 32'd15);
    check("sat_outs", 32'(outs()), 32'(O_RUN));
    @(negedge clock);

    // Reset in the middle of a stalled step.
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clock);
    drive(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0);
    #1;
    check("step_stall_outs", 32'(outs()), 32'(O_STL));
    reset_n = 1'b0;
    #1;
    check("midstep_rst_outs", 32'(outs()), 32'(O_RST));
    check("midstep_rst_cnt", 32'(bus.stallCount), 32'd0);
    @(negedge clock);
    idle();
    reset_n = 1'b1;
    #1;
    check("post_rst_init", 32'(outs()), 32'(O_RST));
    @(negedge clock);
    #1;
    check("post_rst_run", 32'(outs()), 32'(O_RUN));
    check("post_rst_cnt", 32'(bus.stallCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
